data_ram_resp: RTL and testbench

//  Data-memory responder on the CPU ram_* port: the slave end of the load/store bus.

---
 rtl/data_ram_resp_pkg.sv | 25 ++
 rtl/data_ram_resp_ram_bank.sv | 51 +++++
 rtl/data_ram_resp.sv | 123 ++++++++++++
 tb/tb_data_ram_resp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp_pkg
// Description : Shared constants for the data-memory responder: FSM state
//               encodings, wait-counter width and lane geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_resp_pkg;

    // Bus geometry
    localparam int c_reg_w   = 32;
    localparam int c_lanes   = 4;
    localparam int c_lane_w  = 8;

    // Wait-state counter holds 0..15
    localparam int c_cnt_w   = 4;

    // Responder FSM encodings
    localparam int           c_st_w    = 2;
    localparam logic [1:0]   c_st_idle = 2'd0;
    localparam logic [1:0]   c_st_busy = 2'd1;
    localparam logic [1:0]   c_st_ack  = 2'd2;

endpackage : data_ram_resp_pkg
`default_nettype wire

// File: rtl/data_ram_resp_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp_ram_bank
// Description : Four byte-wide synchronous arrays forming one 32-bit word
//               store. Independent lane write enables and a registered read
//               port that only updates when a read is requested, so the read
//               data holds between reads.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_resp_ram_bank
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_lanes-1:0]      i_wr_en,
    input  logic                    i_rd_en,
    input  logic [DEPTH_LOG2-1:0]   i_index,
    input  logic [c_reg_w-1:0]      i_wdata,
    output logic [c_reg_w-1:0]      o_rdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    // Lane i covers bits [8i+7:8i]; sel[3] is the most significant byte
    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
        logic [c_lane_w-1:0] r_mem [0:c_depth-1];
        logic [c_lane_w-1:0] r_rd_byte;

        // Byte write, contents are never cleared
        always_ff @(posedge clk) begin
            if (i_wr_en[i]) begin
                r_mem[i_index] <= i_wdata[c_lane_w*i +: c_lane_w];
            end
        end

        // Read register: cleared by reset, loaded only on a read access
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_byte <= '0;
            end else if (i_rd_en) begin
                r_rd_byte <= r_mem[i_index];
            end
        end

        assign o_rdata[c_lane_w*i +: c_lane_w] = r_rd_byte;
    end

endmodule : data_ram_resp_ram_bank
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp
// Description : Slave end of the CPU load/store bus. Captures one request,
//               inserts WAIT_CYCLES wait states, performs a byte-lane masked
//               write or a full-word read, stalls the pipeline meanwhile and
//               pulses ack_o on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 17,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [3:0]          sel,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    output logic                stall_o,
    output logic                ack_o
);

    localparam logic [c_cnt_w-1:0] c_wait = c_cnt_w'(WAIT_CYCLES);

    logic [c_st_w-1:0]      r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_ack;
    logic                   r_we;
    logic [DEPTH_LOG2-1:0]  r_index;
    logic [c_lanes-1:0]     r_sel;
    logic [c_reg_w-1:0]     r_data;

    logic                   w_access;
    logic [c_lanes-1:0]     w_wr_en;
    logic                   w_rd_en;
    logic                   w_stall;

    // Byte offset and bits above the array size are deliberately dropped
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Access fires on the last wait state; a reset in that cycle cancels it
    assign w_access = (r_state == c_st_busy) && (r_cnt == '0) && !rst;
    assign w_wr_en  = {c_lanes{w_access & r_we}} & r_sel;
    assign w_rd_en  = w_access & ~r_we;

    // Request latch, wait counter and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_index <= '0;
            r_sel   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_ack <= 1'b0;
                    if (ce) begin
                        r_we    <= we;
                        r_index <= addr[DEPTH_LOG2+1:2];
                        r_sel   <= sel;
                        r_data  <= data_i;
                        r_cnt   <= c_wait;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= c_st_ack;
                    end
                end
                c_st_ack: begin
                    r_ack   <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Stall while a request is being captured or serviced, never in reset
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            case (r_state)
                c_st_idle: w_stall = ce;
                c_st_busy: w_stall = 1'b1;
                default:   w_stall = 1'b0;
            endcase
        end
    end

    data_ram_resp_ram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_rd_en (w_rd_en),
        .i_index (r_index),
        .i_wdata (r_data),
        .o_rdata (data_o)
    );

    assign stall_o = w_stall;
    assign ack_o   = r_ack;

endmodule : data_ram_resp
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_resp
// Description : Self-checking bench for data_ram_resp. A vector table drives
//               the main WAIT=1 instance; hand-written sequences cover reset
//               mid-access, back-to-back requests and WAIT=0/WAIT=3 latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_resp;

    localparam int c_depth_log2 = 8;

    logic        clk;
    logic        rst;

    // Main instance, WAIT_CYCLES = 1
    logic        ce, we;
    logic [31:0] addr, data_i, data_o;
    logic [3:0]  sel;
    logic        stall_o, ack_o;

    // Latency instances, WAIT_CYCLES = 0 and 3, sharing one input set
    logic        l_ce, l_we;
    logic [31:0] l_addr, l_data;
    logic [3:0]  l_sel;
    logic [31:0] dout0, dout3;
    logic        stall0, ack0, stall3, ack3;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[14];

    data_ram_resp #(.DEPTH_LOG2(c_depth_log2), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .stall_o(stall_o), .ack_o(ack_o)
    );

    data_ram_resp #(.DEPTH_LOG2(c_depth_log2), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .ce(l_ce), .we(l_we), .addr(l_addr), .sel(l_sel),
        .data_i(l_data), .data_o(dout0), .stall_o(stall0), .ack_o(ack0)
    );

    data_ram_resp #(.DEPTH_LOG2(c_depth_log2), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .ce(l_ce), .we(l_we), .addr(l_addr), .sel(l_sel),
        .data_i(l_data), .data_o(dout3), .stall_o(stall3), .ack_o(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Issue one request on the main instance starting at posedge+1 of an IDLE
    // cycle. ce is dropped and the other inputs scrambled after capture.
    task automatic do_access(input vec_t v, input string tag);
        int          stalls;
        int          ack_at;
        logic [31:0] dout;
        ce = 1'b1; we = v.we; addr = v.addr; sel = v.sel; data_i = v.wdata;
        stalls = 0; ack_at = -1; dout = '0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (stall_o) stalls++;
            if (ack_o) begin
                ack_at = c;
                dout   = data_o;
                break;
            end
            @(posedge clk); #1;
            ce = 1'b0; we = ~v.we; addr = ~v.addr; sel = ~v.sel; data_i = ~v.wdata;
        end
        @(posedge clk); #1;
        check({tag, " ack cycle"}, 32'(ack_at), 32'd3);
        check({tag, " stall cycles"}, 32'(stalls), 32'd3);
        check({tag, " data_o at ack"}, dout, v.exp_dout);
        check({tag, " ack one cycle"}, {31'd0, ack_o}, 32'd0);
    endtask

    initial begin
        int          n_ack;
        int          ack0_at, ack3_at, st0, st3;
        logic [7:0]  stall_pat, ack_pat;
        logic [31:0] b2b_dout;

        n_checks = 0;
        n_pass   = 0;

        //            we    addr          sel      wdata          exp_dout
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h1122_3344};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0100, 32'hAABB_CCDD, 32'h1122_3344};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'h11BB_3344};
        vecs[4]  = '{1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 32'h11BB_3344};
        vecs[5]  = '{1'b1, 32'h0000_0024, 4'b1111, 32'h0102_0304, 32'h11BB_3344};
        vecs[6]  = '{1'b1, 32'h0000_0024, 4'b0000, 32'hFFFF_FFFF, 32'h11BB_3344};
        vecs[7]  = '{1'b0, 32'h0000_0024, 4'b0000, 32'h0000_0000, 32'h0102_0304};
        vecs[8]  = '{1'b1, 32'h0000_0000, 4'b1111, 32'h5A5A_1234, 32'h0102_0304};
        vecs[9]  = '{1'b0, 32'h0000_0400, 4'b0000, 32'h0000_0000, 32'h5A5A_1234};
        vecs[10] = '{1'b1, 32'h0000_0013, 4'b0001, 32'h9988_7766, 32'h5A5A_1234};
        vecs[11] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h11BB_3366};
        vecs[12] = '{1'b0, 32'h8000_0410, 4'b0000, 32'h0000_0000, 32'h11BB_3366};
        vecs[13] = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D};

        // Reset with ce asserted: outputs quiet
        rst = 1'b1;
        ce = 1'b1; we = 1'b0; addr = '0; sel = '0; data_i = '0;
        l_ce = 1'b0; l_we = 1'b0; l_addr = '0; l_sel = '0; l_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_o", data_o, 32'd0);
        check("reset ack_o", {31'd0, ack_o}, 32'd0);
        check("reset stall_o", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;
        ce  = 1'b0;
        @(posedge clk); #1;
        check("idle stall_o", {31'd0, stall_o}, 32'd0);
        check("idle ack_o", {31'd0, ack_o}, 32'd0);

        // Table-driven accesses
        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the final wait state of a write to 0x20
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'b1111; data_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst busy stall_o", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        check("rst data_o", data_o, 32'd0);
        check("rst ack_o", {31'd0, ack_o}, 32'd0);
        check("rst stall_o", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack_o) n_ack++;
        end
        check("rst no ack", 32'(n_ack), 32'd0);
        do_access('{1'b0, 32'h20, 4'b0000, 32'h0, 32'hCAFE_F00D}, "post-rst read");

        // Back-to-back reads with ce held high across the first ack
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'b0000; data_i = '0;
        stall_pat = '0; ack_pat = '0; b2b_dout = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            stall_pat[c] = stall_o;
            ack_pat[c]   = ack_o;
            if (ack_o) b2b_dout = data_o;
            @(posedge clk); #1;
            if (c == 4) ce = 1'b0;
        end
        check("b2b stall pattern", {24'd0, stall_pat}, 32'h77);
        check("b2b ack pattern", {24'd0, ack_pat}, 32'h88);
        check("b2b data_o", b2b_dout, 32'h11BB_3366);

        // Latency of the WAIT=0 and WAIT=3 builds from a one-cycle request
        l_ce = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_sel = 4'b1111; l_data = 32'h0BAD_F00D;
        ack0_at = -1; ack3_at = -1; st0 = 0; st3 = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (stall0) st0++;
            if (stall3) st3++;
            if (ack0 && ack0_at < 0) ack0_at = c;
            if (ack3 && ack3_at < 0) ack3_at = c;
            @(posedge clk); #1;
            l_ce = 1'b0;
        end
        check("wait0 ack cycle", 32'(ack0_at), 32'd2);
        check("wait0 stall cycles", 32'(st0), 32'd2);
        check("wait3 ack cycle", 32'(ack3_at), 32'd5);
        check("wait3 stall cycles", 32'(st3), 32'd5);

        // Read back through both latency builds
        l_ce = 1'b1; l_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            l_ce = 1'b0;
        end
        check("wait0 read data", dout0, 32'h0BAD_F00D);
        check("wait3 read data", dout3, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_data_ram_resp
`default_nettype wire
